// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy game controller.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_SCORE  = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_HIGH   = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd3;

  localparam logic [9:0] GROUND_Y     = 10'd456;
  localparam logic [7:0] DEATH_FRAMES = 8'd60;
  localparam logic [9:0] BIRD_X       = 10'd160;

endpackage

// File: rtl/game_state_ctrl_if.sv
// Avalon-MM slave bus bundle for the game controller register file.
interface game_state_ctrl_if;
  import flappy_pkg::*;

  logic              chipselect;
  logic              write;
  logic              read;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (
    output chipselect, write, read, address, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, write, read, address, writedata,
    output readdata
  );

endinterface

// File: rtl/flap_edge_latch.sv
// Flap request latch: set by a button rising edge or a software request,
// cleared by frame_tick. A request coincident with the tick is reported
// on flap_req in that same cycle so the tick consumes it.
module flap_edge_latch (
  input  logic clk,
  input  logic reset,
  input  logic btn_flap,
  input  logic sw_flap,
  input  logic frame_tick,
  output logic flap_req
);

  logic btn_q;
  logic req_q;
  logic req_now;

  assign req_now  = (btn_flap & ~btn_q) | sw_flap;
  assign flap_req = req_q | req_now;

  // Button history for edge detect, and the request latch itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q <= 1'b0;
      req_q <= 1'b0;
    end else begin
      btn_q <= btn_flap;
      if (frame_tick)
        req_q <= 1'b0;
      else if (req_now)
        req_q <= 1'b1;
    end
  end

endmodule

// File: rtl/game_state_ctrl.sv
// Game flow controller: IDLE/PLAY/DYING/OVER sequencing on frame ticks,
// score keeping, collision flag and an Avalon-MM register window.
// Optional build macro IRQ_EN adds the irq_pend interrupt source.
//
// state | meaning
// IDLE  | waiting for a flap to start; world frozen
// PLAY  | running; score counts pipe passes
// DYING | death animation, DEATH_FRAMES ticks; world frozen
// OVER  | final score shown; flap returns to IDLE
module game_state_ctrl #(
  parameter logic [9:0] GROUND_Y     = flappy_pkg::GROUND_Y,
  parameter logic [7:0] DEATH_FRAMES = flappy_pkg::DEATH_FRAMES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               pixel_valid,
  input  logic               bird_px,
  input  logic               pipe_px,
  input  logic [9:0]         bird_y,
  input  logic               pipe_pass,
  input  logic               btn_flap,
  game_state_ctrl_if.slave   bus,
  output logic [1:0]         game_state,
  output logic               freeze,
  output logic               flap_go,
  output logic               irq
);
  import flappy_pkg::*;

  game_state_t state_q;
  game_state_t state_d;

  logic       flap_req;
  logic       sw_flap;
  logic       wr_en;
  logic       rd_en;
  logic       wr_status;
  logic       overlap;
  logic       hit_q;
  logic       hit_now;
  logic       go_play;
  logic       go_dying;
  logic       go_over;
  logic       score_inc;
  logic       irq_bit;
  logic [7:0] score_q;
  logic [7:0] high_q;
  logic [7:0] frame_cnt_q;
  logic       hit_seen_q;
  logic       unused_wdata;

  assign wr_en     = bus.chipselect & bus.write;
  assign rd_en     = bus.chipselect & bus.read;
  assign sw_flap   = wr_en && (bus.address == ADDR_CTRL) && bus.writedata[0];
  assign wr_status = wr_en && (bus.address == ADDR_STATUS);

  assign unused_wdata = &{1'b0, bus.writedata[7:2]};

  flap_edge_latch u_flap_latch (
    .clk        (clk),
    .reset      (reset),
    .btn_flap   (btn_flap),
    .sw_flap    (sw_flap),
    .frame_tick (frame_tick),
    .flap_req   (flap_req)
  );

  // Ground contact only matters at the tick, where hit_now is consumed.
  assign overlap = pixel_valid & bird_px & pipe_px;
  assign hit_now = hit_q | overlap | (bird_y >= GROUND_Y);

  // Per-frame collision flag, cleared at every tick.
  always_ff @(posedge clk) begin
    if (reset || frame_tick)
      hit_q <= 1'b0;
    else if (overlap)
      hit_q <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic; every transition is gated by frame_tick.
  always_comb begin
    state_d = state_q;
    if (frame_tick) begin
      case (state_q)
        IDLE:    if (flap_req) state_d = PLAY;
        PLAY:    if (hit_now) state_d = DYING;
        DYING:   if (frame_cnt_q == 8'd0) state_d = OVER;
        OVER:    if (flap_req) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State-decoded outputs.
  always_comb begin
    game_state = state_q;
    freeze     = (state_q != PLAY);
  end

  assign go_play   = (state_q == IDLE)  && (state_d == PLAY);
  assign go_dying  = (state_q == PLAY)  && (state_d == DYING);
  assign go_over   = (state_q == DYING) && (state_d == OVER);
  assign score_inc = (state_q == PLAY) && pipe_pass && (score_q != 8'hFF);

  // Flap command follows a consuming tick in IDLE or PLAY, never from OVER.
  always_ff @(posedge clk) begin
    if (reset)
      flap_go <= 1'b0;
    else
      flap_go <= frame_tick && flap_req && ((state_q == IDLE) || (state_q == PLAY));
  end

  // Death-animation frame counter.
  always_ff @(posedge clk) begin
    if (reset)
      frame_cnt_q <= 8'd0;
    else if (go_dying)
      frame_cnt_q <= DEATH_FRAMES - 8'd1;
    else if (frame_tick && (state_q == DYING) && (frame_cnt_q != 8'd0))
      frame_cnt_q <= frame_cnt_q - 8'd1;
  end

  // Score: cleared on game start, saturating count of pipe passes in PLAY.
  always_ff @(posedge clk) begin
    if (reset)
      score_q <= 8'd0;
    else if (go_play)
      score_q <= 8'd0;
    else if (score_inc)
      score_q <= score_q + 8'd1;
  end

  // High score captured on entry to OVER.
  always_ff @(posedge clk) begin
    if (reset)
      high_q <= 8'd0;
    else if (go_over && (score_q > high_q))
      high_q <= score_q;
  end

  // Sticky hit indicator; a new hit wins over a coincident clear.
  always_ff @(posedge clk) begin
    if (reset)
      hit_seen_q <= 1'b0;
    else if (go_dying)
      hit_seen_q <= 1'b1;
    else if (wr_status && bus.writedata[1])
      hit_seen_q <= 1'b0;
  end

`ifdef IRQ_EN
  logic irq_pend_q;

  // Interrupt pending; a set wins over a coincident software clear.
  always_ff @(posedge clk) begin
    if (reset)
      irq_pend_q <= 1'b0;
    else if (go_over || score_inc)
      irq_pend_q <= 1'b1;
    else if (wr_status && bus.writedata[0])
      irq_pend_q <= 1'b0;
  end

  assign irq_bit = irq_pend_q;
  assign irq     = irq_pend_q;
`else
  assign irq_bit = 1'b0;
  assign irq     = 1'b0;
`endif

  // Registered read port, one cycle of latency; holds between reads.
  always_ff @(posedge clk) begin
    if (reset)
      bus.readdata <= 8'd0;
    else if (rd_en) begin
      case (bus.address)
        ADDR_CTRL:   bus.readdata <= {6'b0, state_q};
        ADDR_SCORE:  bus.readdata <= score_q;
        ADDR_HIGH:   bus.readdata <= high_q;
        ADDR_STATUS: bus.readdata <= {6'b0, hit_seen_q, irq_bit};
        default:     bus.readdata <= 8'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed self-checking bench for game_state_ctrl with a read scoreboard.
module tb_game_state_ctrl;

`ifdef IRQ_EN
  localparam logic IRQ = 1'b1;
`else
  localparam logic IRQ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       pixel_valid;
  logic       bird_px;
  logic       pipe_px;
  logic [9:0] bird_y;
  logic       pipe_pass;
  logic       btn_flap;
  logic [1:0] game_state;
  logic       freeze;
  logic       flap_go;
  logic       irq;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb_q[$];
  string      tag_q[$];

  game_state_ctrl_if bus_if ();

  game_state_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .pixel_valid (pixel_valid),
    .bird_px     (bird_px),
    .pipe_px     (pipe_px),
    .bird_y      (bird_y),
    .pipe_pass   (pipe_pass),
    .btn_flap    (btn_flap),
    .bus         (bus_if.slave),
    .game_state  (game_state),
    .freeze      (freeze),
    .flap_go     (flap_go),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic btn_pulse();
    btn_flap = 1'b1;
    @(negedge clk);
    btn_flap = 1'b0;
  endtask

  task automatic pass_pulse();
    pipe_pass = 1'b1;
    @(negedge clk);
    pipe_pass = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus_if.chipselect = 1'b1;
    bus_if.write      = 1'b1;
    bus_if.address    = a;
    bus_if.writedata  = d;
    @(negedge clk);
    bus_if.chipselect = 1'b0;
    bus_if.write      = 1'b0;
    bus_if.writedata  = 8'd0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] e;
    string      t;
    sb_q.push_back(exp);
    tag_q.push_back(tag);
    bus_if.chipselect = 1'b1;
    bus_if.read       = 1'b1;
    bus_if.address    = a;
    @(negedge clk);
    bus_if.chipselect = 1'b0;
    bus_if.read       = 1'b0;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    chk(t, bus_if.readdata, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; frame_tick = 1'b0; pixel_valid = 1'b0; bird_px = 1'b0; pipe_px = 1'b0;
    bird_y = 10'd0; pipe_pass = 1'b0; btn_flap = 1'b0;
    bus_if.chipselect = 1'b0; bus_if.write = 1'b0; bus_if.read = 1'b0;
    bus_if.address = 2'd0; bus_if.writedata = 8'd0;
    cyc(3);
    chk("rst_state", {6'b0, game_state}, 8'd0);
    chk("rst_freeze", {7'b0, freeze}, 8'd1);
    chk("rst_flap_go", {7'b0, flap_go}, 8'd0);
    chk("rst_irq", {7'b0, irq}, 8'd0);
    chk("rst_readdata", bus_if.readdata, 8'd0);
    reset = 1'b0;
    cyc(1);
    rd(2'd1, 8'd0, "rst_score");
    rd(2'd2, 8'd0, "rst_high");
    rd(2'd3, 8'd0, "rst_status");

    // Button flap starts the game; flap_go one cycle after the tick.
    btn_pulse();
    cyc(2);
    chk("pre_tick_flap_go", {7'b0, flap_go}, 8'd0);
    tick();
    chk("start_state", {6'b0, game_state}, 8'd1);
    chk("start_freeze", {7'b0, freeze}, 8'd0);
    chk("start_flap_go", {7'b0, flap_go}, 8'd1);
    cyc(1);
    chk("start_flap_go_end", {7'b0, flap_go}, 8'd0);

    // Mid-frame pipe collision, then the death animation.
    cyc(3);
    pixel_valid = 1'b1; bird_px = 1'b1; pipe_px = 1'b1;
    cyc(1);
    pixel_valid = 1'b0; bird_px = 1'b0; pipe_px = 1'b0;
    cyc(3);
    chk("play_before_tick", {6'b0, game_state}, 8'd1);
    tick();
    chk("hit_dying", {6'b0, game_state}, 8'd2);
    chk("dying_freeze", {7'b0, freeze}, 8'd1);
    rd(2'd3, 8'h02, "hit_seen");
    pass_pulse();
    rd(2'd1, 8'd0, "dying_pass_ignored");
    repeat (59) tick();
    chk("dying_59", {6'b0, game_state}, 8'd2);
    tick();
    chk("over_60", {6'b0, game_state}, 8'd3);
    rd(2'd0, 8'd3, "rd_state_over");
    rd(2'd2, 8'd0, "high_g1");
    rd(2'd3, {6'b0, 1'b1, IRQ}, "status_over1");
    wr(2'd3, 8'h03);
    rd(2'd3, 8'd0, "status_cleared");

    // OVER back to IDLE without a flap command.
    btn_pulse();
    tick();
    chk("over_idle", {6'b0, game_state}, 8'd0);
    chk("over_idle_no_flap", {7'b0, flap_go}, 8'd0);

    // Software flap start, score saturation, ground boundary.
    wr(2'd0, 8'h01);
    cyc(2);
    tick();
    chk("sw_start", {6'b0, game_state}, 8'd1);
    chk("sw_flap_go", {7'b0, flap_go}, 8'd1);
    repeat (3) begin pass_pulse(); cyc(1); end
    rd(2'd1, 8'd3, "score_3");
    repeat (297) begin pass_pulse(); cyc(1); end
    rd(2'd1, 8'd255, "score_sat");
    bird_y = 10'd455;
    tick();
    chk("y455_stays", {6'b0, game_state}, 8'd1);
    bird_y = 10'd456;
    tick();
    bird_y = 10'd0;
    chk("y456_dying", {6'b0, game_state}, 8'd2);
    repeat (60) tick();
    chk("over_g2", {6'b0, game_state}, 8'd3);
    rd(2'd2, 8'd255, "high_255");
    wr(2'd3, 8'h03);

    // Software flap coincident with the tick is consumed by it.
    btn_pulse();
    tick();
    chk("idle_g3", {6'b0, game_state}, 8'd0);
    frame_tick = 1'b1;
    bus_if.chipselect = 1'b1; bus_if.write = 1'b1;
    bus_if.address = 2'd0; bus_if.writedata = 8'h01;
    @(negedge clk);
    frame_tick = 1'b0;
    bus_if.chipselect = 1'b0; bus_if.write = 1'b0; bus_if.writedata = 8'd0;
    chk("sw_same_tick", {6'b0, game_state}, 8'd1);
    chk("sw_same_tick_flap", {7'b0, flap_go}, 8'd1);
    cyc(1);
    tick();
    chk("req_consumed", {7'b0, flap_go}, 8'd0);
    rd(2'd1, 8'd0, "score_cleared");

    // Interrupt on a score increment, then reset during DYING with a tick.
    pass_pulse();
    chk("irq_on_pass", {7'b0, irq}, {7'b0, IRQ});
    wr(2'd3, 8'h01);
    chk("irq_cleared", {7'b0, irq}, 8'd0);
    rd(2'd1, 8'd1, "score_one");
    bird_y = 10'd500;
    tick();
    bird_y = 10'd0;
    chk("dying_g3", {6'b0, game_state}, 8'd2);
    repeat (5) tick();
    reset = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    frame_tick = 1'b0;
    chk("rst_dying_state", {6'b0, game_state}, 8'd0);
    chk("rst_dying_freeze", {7'b0, freeze}, 8'd1);
    rd(2'd1, 8'd0, "rst_dying_score");
    rd(2'd2, 8'd0, "rst_dying_high");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
